// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the instruction/data memory arbiter:
//   WORD_W  - width of addresses and data words
//   word_t  - one address/data word
//   state_e - arbiter FSM states (IDLE, BUSY, DONE)
//   grant_e - current or last owner of the memory port (NONE, INSTR, DATA)
package mem_arb_pkg;

    localparam int unsigned WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2
    } grant_e;

endpackage

// File: rtl/arb_lat_cnt.sv
// arb_lat_cnt
// 4-bit down counter that times one memory access.
//   clk      in  clock
//   rst      in  synchronous active-high reset (count -> 0)
//   load     in  load load_val (has priority over dec)
//   dec      in  decrement by one; holds at zero
//   load_val in  value loaded on load
//   zero_o   out count is zero
module arb_lat_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dec,
    input  logic [3:0] load_val,
    output logic       zero_o
);

    logic [3:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates one shared single-port memory between an instruction-fetch
// requester and a data (read/write) requester. Each access occupies the
// memory port for MEM_LAT cycles (BUSY), then a one-cycle DONE pulse is
// returned to the winner.
// Parameters:
//   MEM_LAT   memory latency in cycles, 1..15
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_req, i_addr                 fetch request / word address
//   i_rdata, i_done               fetched word (registered) / completion pulse
//   d_req, d_we, d_addr, d_wdata  data request / write enable / address / data
//   d_rdata, d_done               read word (registered) / completion pulse
//   mem_en, mem_we, mem_addr,     registered memory strobes, held for the
//   mem_wdata                     whole access
//   mem_rdata                     memory read data, valid in last access cycle
// Build option:
//   ARB_ROUND_ROBIN_EN  when defined, simultaneous requests alternate using a
//                       last-grant register; otherwise data always wins.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [WORD_W-1:0] i_addr,
    output logic [WORD_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_e state_q, state_d;
    grant_e grant_q, grant_d;
    grant_e winner;

    word_t  i_rdata_q, d_rdata_q, mem_addr_q, mem_wdata_q;
    logic   i_done_q, d_done_q, mem_en_q, mem_we_q;

    logic   accept;
    logic   cnt_load, cnt_dec, cnt_zero;

`ifdef ARB_ROUND_ROBIN_EN
    grant_e last_q;
`endif

    // Winner among the current requests; only meaningful in IDLE.
    always_comb begin
        winner = INSTR;
`ifdef ARB_ROUND_ROBIN_EN
        if (i_req && d_req) begin
            winner = (last_q == INSTR) ? DATA : INSTR;
        end else if (d_req) begin
            winner = DATA;
        end
`else
        if (d_req) begin
            winner = DATA;
        end
`endif
    end

    assign accept = (state_q == IDLE) && (i_req || d_req);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = BUSY;
                    grant_d  = winner;
                    cnt_load = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_zero) begin
                    state_d = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = NONE;
            end
            default: begin
                state_d = IDLE;
                grant_d = NONE;
            end
        endcase
    end

    arb_lat_cnt u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (LAT_LOAD),
        .zero_o   (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= NONE;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        mem_en_q <= 1'b1;
                        if (winner == DATA) begin
                            mem_we_q    <= d_we;
                            mem_addr_q  <= d_addr;
                            mem_wdata_q <= d_wdata;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= i_addr;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                BUSY: begin
                    // Last memory cycle: capture read data and raise done.
                    if (cnt_zero) begin
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        if (grant_q == DATA) begin
                            d_done_q <= 1'b1;
                            if (!mem_we_q) begin
                                d_rdata_q <= mem_rdata;
                            end
                        end else begin
                            i_done_q  <= 1'b1;
                            i_rdata_q <= mem_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= INSTR;
        end else if (accept) begin
            last_q <= winner;
        end
    end
`endif

    assign i_rdata   = i_rdata_q;
    assign i_done    = i_done_q;
    assign d_rdata   = d_rdata_q;
    assign d_done    = d_done_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter: instance u0 with MEM_LAT=4, instance u1
// with MEM_LAT=1. Memory models are combinational address functions:
//   u0: 0x0010 -> 0xA5A5, otherwise addr ^ 0x5A5A
//   u1: addr ^ 0x5A5A
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic        i_req0, d_req0, d_we0;
    logic [15:0] i_addr0, d_addr0, d_wdata0;
    logic [15:0] i_rdata0, d_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
    logic        i_done0, d_done0, mem_en0, mem_we0;

    logic        i_req1, d_req1, d_we1;
    logic [15:0] i_addr1, d_addr1, d_wdata1;
    logic [15:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        i_done1, d_done1, mem_en1, mem_we1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata0 = (mem_addr0 == 16'h0010) ? 16'hA5A5 : (mem_addr0 ^ 16'h5A5A);
    assign mem_rdata1 = mem_addr1 ^ 16'h5A5A;

    mem_arbiter #(.MEM_LAT(4)) u0 (
        .clk(clk), .rst(rst),
        .i_req(i_req0), .i_addr(i_addr0), .i_rdata(i_rdata0), .i_done(i_done0),
        .d_req(d_req0), .d_we(d_we0), .d_addr(d_addr0), .d_wdata(d_wdata0),
        .d_rdata(d_rdata0), .d_done(d_done0),
        .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
    );

    mem_arbiter #(.MEM_LAT(1)) u1 (
        .clk(clk), .rst(rst),
        .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_done(i_done1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_rdata(d_rdata1), .d_done(d_done1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a done pulse on u0; reports cycle and which pulse.
    task automatic wait_any(input string tag, output int at, output logic gi, output logic gd);
        at = -1;
        gi = 1'b0;
        gd = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (i_done0 || d_done0) begin
                gi = i_done0;
                gd = d_done0;
                at = cyc;
                break;
            end
        end
        checks++;
        assert (at >= 0) else begin
            failures++;
            $error("FAIL %s: observed=timeout expected=done pulse", tag);
        end
    endtask

    initial begin
        int   t1, t2, tacc;
        logic gi, gd;

        rst = 1'b1;
        i_req0 = 1'b0; d_req0 = 1'b0; d_we0 = 1'b0;
        i_addr0 = '0; d_addr0 = '0; d_wdata0 = '0;
        i_req1 = 1'b0; d_req1 = 1'b0; d_we1 = 1'b0;
        i_addr1 = '0; d_addr1 = '0; d_wdata1 = '0;

        // Reset state
        tick();
        tick();
        chk("rst_mem_en", mem_en0, 0);
        chk("rst_mem_we", mem_we0, 0);
        chk("rst_mem_addr", mem_addr0, 0);
        chk("rst_i_done", i_done0, 0);
        chk("rst_d_done", d_done0, 0);
        chk("rst_i_rdata", i_rdata0, 0);
        chk("rst_d_rdata", d_rdata0, 0);
        chk("rst_u1_mem_en", mem_en1, 0);
        rst = 1'b0;

        // Fetch only, accepted on first edge after reset release
        i_req0 = 1'b1; i_addr0 = 16'h0010;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("f_mem_en", mem_en0, 1);
            chk("f_mem_addr", mem_addr0, 16'h0010);
            chk("f_mem_we", mem_we0, 0);
            chk("f_i_done_early", i_done0, 0);
            tick();
        end
        chk("f_i_done", i_done0, 1);
        chk("f_d_done", d_done0, 0);
        chk("f_done_mem_en", mem_en0, 0);
        chk("f_i_rdata", i_rdata0, 16'hA5A5);
        i_req0 = 1'b0;
        tick();
        chk("f_i_done_pulse", i_done0, 0);
        chk("f_i_rdata_hold", i_rdata0, 16'hA5A5);
        chk("f_idle_mem_en", mem_en0, 0);

        // Simultaneous fetch and data read: data first, fetch 6 cycles later
        i_req0 = 1'b1; i_addr0 = 16'h0020;
        d_req0 = 1'b1; d_we0 = 1'b0; d_addr0 = 16'h8000;
        wait_any("s_first_wait", t1, gi, gd);
        chk("s_first_is_data", gd, 1);
        chk("s_first_not_instr", gi, 0);
        chk("s_d_rdata", d_rdata0, 16'hDA5A);
        d_req0 = 1'b0;
        wait_any("s_second_wait", t2, gi, gd);
        chk("s_second_is_instr", gi, 1);
        chk("s_gap", t2 - t1, 6);
        chk("s_i_rdata", i_rdata0, 16'h5A7A);
        i_req0 = 1'b0;
        tick();

        // Both requests held and re-issued for four accesses
        i_req0 = 1'b1; i_addr0 = 16'h0020;
        d_req0 = 1'b1; d_we0 = 1'b0; d_addr0 = 16'h8000;
        for (int k = 0; k < 4; k++) begin
            wait_any("o_wait", t1, gi, gd);
`ifdef ARB_ROUND_ROBIN_EN
            chk("o_order_data", gd, (k % 2 == 0) ? 1 : 0);
`else
            chk("o_order_data", gd, 1);
`endif
            if (k == 3) begin
                i_req0 = 1'b0;
                d_req0 = 1'b0;
            end
        end
        tick();
        chk("o_d_rdata", d_rdata0, 16'hDA5A);

        // Data write: strobes held for MEM_LAT cycles, d_rdata untouched
        d_req0 = 1'b1; d_we0 = 1'b1; d_addr0 = 16'h0100; d_wdata0 = 16'h1234;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("w_mem_en", mem_en0, 1);
            chk("w_mem_we", mem_we0, 1);
            chk("w_mem_addr", mem_addr0, 16'h0100);
            chk("w_mem_wdata", mem_wdata0, 16'h1234);
            tick();
        end
        chk("w_d_done", d_done0, 1);
        chk("w_i_done", i_done0, 0);
        chk("w_mem_en_off", mem_en0, 0);
        chk("w_d_rdata_kept", d_rdata0, 16'hDA5A);
        d_req0 = 1'b0; d_we0 = 1'b0;
        tick();

        // Reset in the second BUSY cycle aborts the access
        i_req0 = 1'b1; i_addr0 = 16'h0010;
        tick();
        chk("r_busy1_mem_en", mem_en0, 1);
        tick();
        rst = 1'b1;
        tick();
        chk("r_mem_en", mem_en0, 0);
        chk("r_i_done", i_done0, 0);
        chk("r_i_rdata", i_rdata0, 0);
        rst = 1'b0;
        tick();
        tacc = cyc;
        chk("r_reaccept_mem_en", mem_en0, 1);
        chk("r_reaccept_i_done", i_done0, 0);
        wait_any("r_wait", t1, gi, gd);
        chk("r_done_instr", gi, 1);
        chk("r_latency", t1 - tacc, 4);
        chk("r_i_rdata_new", i_rdata0, 16'hA5A5);
        i_req0 = 1'b0;
        tick();

        // MEM_LAT=1 back-to-back fetches: period of three cycles
        i_req1 = 1'b1; i_addr1 = 16'h0030;
        tick();
        for (int k = 0; k < 6; k++) begin
            chk("l1_mem_en", mem_en1, (k % 3 == 0) ? 1 : 0);
            chk("l1_i_done", i_done1, (k % 3 == 1) ? 1 : 0);
            if (k % 3 == 1) chk("l1_i_rdata", i_rdata1, 16'h5A6A);
            tick();
        end
        i_req1 = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
